// File: rtl/simple_axi_write_burster_pkg.sv
// Shared definitions for the simple AXI write burster.
// Contents: FSM state encoding, AXI burst/response constants, AXI field
// widths, the 4 KB boundary constant and the awsize-from-width helper.
package simple_axi_write_burster_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_ADDR,
    ST_DATA,
    ST_DRAIN
  } state_t;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned AXI_ID_W       = 4;
  localparam int unsigned AXI_LEN_W      = 8;
  localparam int unsigned BOUNDARY_4K    = 4096;

  // AXI awsize encoding: log2 of the bytes per beat.
  function automatic logic [2:0] axi_size(input int unsigned data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/simple_axi_write_burster_calc.sv
// write_burst_calc: combinational burst arithmetic for the write burster.
// Ports:
//   addr_lo     - low 12 bits of the current burst start address
//   remaining   - beats still to be issued in this transfer
//   len         - byte length of an incoming command
//   len_rem     - latched (length mod bytes-per-beat) of the active transfer
//   total_beats - ceil(len / bytes-per-beat)
//   burst_beats - min(MAX_BURST, remaining, beats to the next 4 KB boundary)
//   final_strb  - strobe for the last beat of the transfer
module write_burst_calc
  import simple_axi_write_burster_pkg::*;
#(
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned LEN_W      = 20,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic [11:0]                        addr_lo,
  input  logic [LEN_W-1:0]                   remaining,
  input  logic [LEN_W-1:0]                   len,
  input  logic [$clog2(AXI_DATA_W/8)-1:0]    len_rem,
  output logic [LEN_W-1:0]                   total_beats,
  output logic [$clog2(MAX_BURST):0]         burst_beats,
  output logic [AXI_DATA_W/8-1:0]            final_strb
);

  localparam int unsigned BYTES  = AXI_DATA_W / 8;
  localparam int unsigned BSHIFT = $clog2(BYTES);
  localparam int unsigned BW     = $clog2(MAX_BURST) + 1;
  localparam int unsigned CW     = (LEN_W > 13) ? LEN_W : 13;

  logic [LEN_W:0] len_round;
  logic [12:0]    to_4k_bytes;
  logic [CW-1:0]  to_4k_beats;
  logic [CW-1:0]  pick;

  // Round the byte length up to whole beats.
  assign len_round   = {1'b0, len} + (LEN_W+1)'(BYTES - 1);
  assign total_beats = LEN_W'(len_round >> BSHIFT);

  // Beats left before the address crosses a 4 KB page.
  assign to_4k_bytes = 13'(BOUNDARY_4K) - {1'b0, addr_lo};
  assign to_4k_beats = CW'(to_4k_bytes >> BSHIFT);

  always_comb begin
    pick = CW'(MAX_BURST);
    if (CW'(remaining) < pick) pick = CW'(remaining);
    if (to_4k_beats < pick)    pick = to_4k_beats;
    burst_beats = BW'(pick);
  end

  // A zero remainder means the last beat is fully populated.
  always_comb begin
    final_strb = '0;
    for (int i = 0; i < int'(BYTES); i++) begin
      final_strb[i] = (len_rem == '0) || (i < int'(len_rem));
    end
  end

endmodule

// File: rtl/simple_axi_write_burster.sv
// simple_axi_write_burster: splits a byte-length write command into AXI4
// INCR bursts that never exceed MAX_BURST beats or cross a 4 KB page.
// Optional macro SIMPLE_AXI_WRITE_BRESP_EN enables write-response tracking:
// an outstanding-burst limit, completion after the last response and a
// sticky error flag from non-OKAY bresp.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   m_wvalid/m_wready   - command valid in IDLE, beat handshake in DATA
//   m_waddr/m_wlen      - start address and byte length, latched in IDLE
//   m_wdata             - beat data, passed straight to m_axi_wdata
//   m_wlast             - final beat of the transfer
//   done, error         - completion pulse, sticky response error
//   m_axi_aw*/w*/b*     - AXI4 write address, data and response channels
module simple_axi_write_burster
  import simple_axi_write_burster_pkg::*;
#(
  parameter int unsigned AXI_ADDR_W      = 32,
  parameter int unsigned AXI_DATA_W      = 32,
  parameter int unsigned LEN_W           = 20,
  parameter int unsigned MAX_BURST       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m_wvalid,
  output logic                    m_wready,
  input  logic [AXI_ADDR_W-1:0]   m_waddr,
  input  logic [AXI_DATA_W-1:0]   m_wdata,
  input  logic [LEN_W-1:0]        m_wlen,
  output logic                    m_wlast,
  output logic                    done,
  output logic                    error,
  output logic [AXI_ID_W-1:0]     m_axi_awid,
  output logic [AXI_ADDR_W-1:0]   m_axi_awaddr,
  output logic [AXI_LEN_W-1:0]    m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [AXI_DATA_W-1:0]   m_axi_wdata,
  output logic [AXI_DATA_W/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  localparam int unsigned BSHIFT = $clog2(AXI_DATA_W / 8);
  localparam int unsigned BW     = $clog2(MAX_BURST) + 1;

  state_t                 state, state_n;
  logic [AXI_ADDR_W-1:0]  cur_addr, cur_addr_n;
  logic [BSHIFT-1:0]      len_rem_q, len_rem_n;
  logic [LEN_W-1:0]       remaining, remaining_n;
  logic [AXI_ADDR_W-1:0]  awaddr_q, awaddr_n;
  logic [AXI_LEN_W-1:0]   awlen_q, awlen_n;
  logic [AXI_LEN_W-1:0]   beat_cnt, beat_n;
  logic                   awvalid_q, awvalid_n;
  logic                   done_q, done_n;
  logic                   error_q, error_n;
  logic                   stall;

  logic [LEN_W-1:0]        total_beats;
  logic [BW-1:0]           burst_beats;
  logic [AXI_DATA_W/8-1:0] final_strb;
  logic [LEN_W-1:0]        burst_len;
  logic [AXI_ADDR_W-1:0]   burst_bytes;
  logic                    last_in_burst, last_burst, final_beat;

  write_burst_calc #(
    .AXI_DATA_W (AXI_DATA_W),
    .LEN_W      (LEN_W),
    .MAX_BURST  (MAX_BURST)
  ) u_calc (
    .addr_lo     (cur_addr[11:0]),
    .remaining   (remaining),
    .len         (m_wlen),
    .len_rem     (len_rem_q),
    .total_beats (total_beats),
    .burst_beats (burst_beats),
    .final_strb  (final_strb)
  );

  // Fixed write-address attributes.
  assign m_axi_awid    = '0;
  assign m_axi_awsize  = axi_size(AXI_DATA_W);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd2;
  assign m_axi_awprot  = 3'b010;
  assign m_axi_awqos   = '0;
  assign m_axi_bready  = 1'b1;

  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awvalid = awvalid_q;
  assign done          = done_q;
  assign error         = error_q;

  assign burst_len     = LEN_W'(awlen_q) + LEN_W'(1);
  assign burst_bytes   = (AXI_ADDR_W'(awlen_q) + AXI_ADDR_W'(1)) << BSHIFT;
  assign last_in_burst = (beat_cnt == awlen_q);
  assign last_burst    = (remaining == burst_len);
  assign final_beat    = last_in_burst && last_burst;

`ifdef SIMPLE_AXI_WRITE_BRESP_EN
  logic [3:0] outstanding, outstanding_n;
  logic       aw_hs, b_hs;

  assign aw_hs = awvalid_q && m_axi_awready;
  assign b_hs  = m_axi_bvalid && m_axi_bready;
  assign stall = (outstanding == 4'(MAX_OUTSTANDING));

  // Simultaneous issue and retire leave the count unchanged.
  always_comb begin
    outstanding_n = outstanding;
    if (aw_hs && !b_hs)                          outstanding_n = outstanding + 4'd1;
    else if (!aw_hs && b_hs && outstanding != '0) outstanding_n = outstanding - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) outstanding <= '0;
    else     outstanding <= outstanding_n;
  end
`else
  logic unused_bresp;
  assign unused_bresp = ^{m_axi_bresp, m_axi_bvalid};
  assign stall        = 1'b0;
`endif

  // Next-state and channel outputs.
  always_comb begin
    state_n      = state;
    cur_addr_n   = cur_addr;
    len_rem_n    = len_rem_q;
    remaining_n  = remaining;
    awaddr_n     = awaddr_q;
    awlen_n      = awlen_q;
    beat_n       = beat_cnt;
    awvalid_n    = awvalid_q;
    done_n       = 1'b0;
    error_n      = error_q;
    m_wready     = 1'b0;
    m_wlast      = 1'b0;
    m_axi_wvalid = 1'b0;
    m_axi_wlast  = 1'b0;
    m_axi_wstrb  = '1;
    m_axi_wdata  = m_wdata;

    case (state)
      ST_IDLE: begin
        if (m_wvalid) begin
          cur_addr_n  = m_waddr;
          len_rem_n   = m_wlen[BSHIFT-1:0];
          remaining_n = total_beats;
          error_n     = 1'b0;
          state_n     = ST_CALC;
        end
      end
      ST_CALC: begin
        if (remaining == '0) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end else if (!stall) begin
          awaddr_n  = cur_addr;
          awlen_n   = AXI_LEN_W'(burst_beats - BW'(1));
          awvalid_n = 1'b1;
          beat_n    = '0;
          state_n   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_axi_awready) begin
          awvalid_n = 1'b0;
          state_n   = ST_DATA;
        end
      end
      ST_DATA: begin
        m_axi_wvalid = m_wvalid;
        m_wready     = m_axi_wready;
        m_axi_wlast  = last_in_burst;
        m_wlast      = final_beat;
        if (final_beat) m_axi_wstrb = final_strb;
        if (m_wvalid && m_axi_wready) begin
          beat_n = beat_cnt + AXI_LEN_W'(1);
          if (last_in_burst) begin
            cur_addr_n  = cur_addr + burst_bytes;
            remaining_n = remaining - burst_len;
            state_n     = last_burst ? ST_DRAIN : ST_CALC;
          end
        end
      end
      ST_DRAIN: begin
`ifdef SIMPLE_AXI_WRITE_BRESP_EN
        if (outstanding == '0) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
`else
        done_n  = 1'b1;
        state_n = ST_IDLE;
`endif
      end
      default: state_n = ST_IDLE;
    endcase

`ifdef SIMPLE_AXI_WRITE_BRESP_EN
    if (b_hs && (m_axi_bresp != AXI_RESP_OKAY)) error_n = 1'b1;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_addr  <= '0;
      len_rem_q <= '0;
      remaining <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      beat_cnt  <= '0;
      awvalid_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state     <= state_n;
      cur_addr  <= cur_addr_n;
      len_rem_q <= len_rem_n;
      remaining <= remaining_n;
      awaddr_q  <= awaddr_n;
      awlen_q   <= awlen_n;
      beat_cnt  <= beat_n;
      awvalid_q <= awvalid_n;
      done_q    <= done_n;
      error_q   <= error_n;
    end
  end

endmodule

// File: tb/tb_simple_axi_write_burster.sv
// Scoreboard bench for simple_axi_write_burster (32-bit data, 16-beat bursts,
// one outstanding burst when response tracking is built in).
module tb_simple_axi_write_burster;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          m_wvalid, m_wready, m_wlast, done, error;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [LW-1:0] m_wlen;
  logic [3:0]    awid, awcache, awqos;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize, awprot;
  logic [1:0]    awburst, bresp;
  logic          awlock, awvalid, awready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wlast, wvalid, wready, bvalid, bready;

  simple_axi_write_burster #(
    .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .LEN_W(LW), .MAX_BURST(16), .MAX_OUTSTANDING(1)
  ) dut (
    .clk(clk), .rst(rst), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_waddr(m_waddr),
    .m_wdata(m_wdata), .m_wlen(m_wlen), .m_wlast(m_wlast), .done(done), .error(error),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [7:0] len; } aw_exp_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; logic xlast; } w_exp_t;

  aw_exp_t     aw_q[$];
  w_exp_t      w_q[$];
  int unsigned bq[$];

  int          checks = 0, passes = 0;
  int unsigned cyc = 0;
  int          done_cnt = 0, aw_cnt = 0, b_cnt = 0;
  int          cur_test = 0;
  int unsigned b_delay = 2;
  logic [1:0]  bresp_cfg = 2'b00;
  bit          mon_en = 1'b1;
  bit          rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] pat(input int t, input int k);
    return {8'(t), 24'(k)};
  endfunction

  // Expected aw entry plus its beats; k0 is the transfer-relative first beat.
  task automatic exp_burst(input logic [31:0] addr, input int len, input int k0,
                           input bit final_b, input logic [3:0] fstrb);
    w_exp_t w;
    aw_q.push_back('{addr: addr, len: 8'(len)});
    for (int i = 0; i <= len; i++) begin
      w.data  = pat(cur_test, k0 + i);
      w.strb  = (final_b && i == len) ? fstrb : 4'hF;
      w.last  = (i == len);
      w.xlast = final_b && (i == len);
      w_q.push_back(w);
    end
  endtask

  // Issue a command and feed its beats, then wait for done.
  task automatic drive(input logic [31:0] addr, input logic [19:0] len, input int nbeats);
    int k, n, d0;
    bit hs;
    d0 = done_cnt;
    @(negedge clk);
    m_waddr = addr; m_wlen = len; m_wvalid = 1'b1; k = 0; n = 0;
    m_wdata = pat(cur_test, 0);
    while (k < nbeats && n < 1000) begin
      #4 hs = m_wready;
      @(negedge clk);
      n++;
      if (hs) k++;
      m_wdata = pat(cur_test, k);
    end
    if (nbeats == 0) @(negedge clk);
    m_wvalid = 1'b0;
    check("beats_accepted", 64'(k), 64'(nbeats));
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_pulse", 64'(done_cnt - d0), 64'd1);
    check("aw_drained", 64'(aw_q.size()), 64'd0);
    check("w_drained", 64'(w_q.size()), 64'd0);
  endtask

  // AXI slave: ready generation and delayed write responses.
  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    forever begin
      @(negedge clk);
      awready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid  = (bq.size() > 0) && (cyc >= bq[0]);
      bresp   = bresp_cfg;
    end
  end

  // Monitor: compare every handshake against the scoreboard queues.
  initial begin
    aw_exp_t ea;
    w_exp_t  ew;
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        if (mon_en && awvalid && awready) begin
          if (aw_q.size() == 0) begin
            checks++;
            $display("FAIL aw_unexpected: got awaddr 0x%0h required no request", awaddr);
          end else begin
            ea = aw_q.pop_front();
            check("awaddr", 64'(awaddr), 64'(ea.addr));
            check("awlen", 64'(awlen), 64'(ea.len));
            check("aw_fixed", 64'({awid, awsize, awburst, awlock, awcache, awprot, awqos}),
                  64'({4'h0, 3'd2, 2'b01, 1'b0, 4'd2, 3'b010, 4'h0}));
          end
`ifdef SIMPLE_AXI_WRITE_BRESP_EN
          check("aw_outstanding", 64'(aw_cnt - b_cnt), 64'd0);
`endif
          aw_cnt++;
        end
        if (mon_en && wvalid && wready) begin
          if (w_q.size() == 0) begin
            checks++;
            $display("FAIL w_unexpected: got wdata 0x%0h required no beat", wdata);
          end else begin
            ew = w_q.pop_front();
            check("wdata", 64'(wdata), 64'(ew.data));
            check("wstrb", 64'(wstrb), 64'(ew.strb));
            check("wlast", 64'(wlast), 64'(ew.last));
            check("m_wlast", 64'(m_wlast), 64'(ew.xlast));
          end
          if (wlast) bq.push_back(cyc + b_delay);
        end
        if (bvalid && bready) begin
          b_cnt++;
          if (bq.size() > 0) void'(bq.pop_front());
        end
        if (done) begin
          done_cnt++;
`ifdef SIMPLE_AXI_WRITE_BRESP_EN
          if (mon_en) check("done_after_b", 64'(b_cnt), 64'(aw_cnt));
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; m_wvalid = 1'b0; m_waddr = '0; m_wdata = '0; m_wlen = '0;
    repeat (3) @(negedge clk);
    check("rst_awvalid", 64'(awvalid), 64'd0);
    check("rst_done_err", 64'({done, error}), 64'd0);
    check("rst_wready", 64'({m_wready, wvalid, m_wlast}), 64'd0);
    rst = 1'b0;

    // Single aligned 16-beat burst.
    cur_test = 1;
    exp_burst(32'h0, 15, 0, 1'b1, 4'hF);
    drive(32'h0, 20'd64, 16);
    check("err_ok_a", 64'(error), 64'd0);

    // Split at the 4 KB boundary.
    cur_test = 2;
    exp_burst(32'hFF8, 1, 0, 1'b0, 4'hF);
    exp_burst(32'h1000, 5, 2, 1'b1, 4'hF);
    drive(32'hFF8, 20'd32, 8);

    // Partial last beat: 10 bytes -> strobe 0x3.
    cur_test = 3;
    exp_burst(32'h100, 2, 0, 1'b1, 4'h3);
    drive(32'h100, 20'd10, 3);

    // Zero length: no AXI traffic, done within 3 cycles.
    cur_test = 4;
    @(negedge clk);
    m_waddr = 32'h40; m_wlen = '0; m_wvalid = 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      m_wvalid = 1'b0;
      check("len0_no_aw", 64'({awvalid, wvalid, m_wlast}), 64'd0);
      if (done) begin
        n = i + 1;
        break;
      end
    end
    check("len0_done_seen", 64'(n != 0), 64'd1);
    repeat (2) @(negedge clk);

    // One beat up to the page end, then a one-beat partial tail.
    cur_test = 5;
    exp_burst(32'hFFC, 0, 0, 1'b0, 4'hF);
    exp_burst(32'h1000, 0, 1, 1'b1, 4'h3);
    drive(32'hFFC, 20'd6, 2);

    // Two full bursts with slow SLVERR responses.
    cur_test = 6;
    b_delay = 20; bresp_cfg = 2'b10;
    exp_burst(32'h200, 15, 0, 1'b0, 4'hF);
    exp_burst(32'h240, 15, 16, 1'b1, 4'hF);
    drive(32'h200, 20'd128, 32);
`ifdef SIMPLE_AXI_WRITE_BRESP_EN
    check("err_slverr", 64'(error), 64'd1);
`else
    check("err_tied", 64'(error), 64'd0);
`endif
    b_delay = 2; bresp_cfg = 2'b00;

    // Randomised readiness, 39 bytes -> final strobe 0x7.
    cur_test = 7;
    rand_rdy = 1'b1;
    exp_burst(32'h300, 9, 0, 1'b1, 4'h7);
    drive(32'h300, 20'd39, 10);
    check("err_cleared", 64'(error), 64'd0);

    // Reset in the middle of a data burst.
    cur_test = 8;
    mon_en = 1'b0;
    @(negedge clk);
    m_waddr = 32'h0; m_wlen = 20'd64; m_wvalid = 1'b1; m_wdata = 32'hDEAD_BEEF;
    n = 0;
    while (!wvalid && n < 50) begin
      @(negedge clk);
      #4 n++;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1; m_wvalid = 1'b0;
    @(negedge clk);
    check("mid_rst_aw", 64'({awvalid, awaddr, awlen}), 64'd0);
    check("mid_rst_w", 64'({wvalid, m_wready, m_wlast}), 64'd0);
    check("mid_rst_flags", 64'({done, error}), 64'd0);
    aw_q.delete(); w_q.delete(); bq.delete();
    aw_cnt = 0; b_cnt = 0;
    rst = 1'b0; mon_en = 1'b1;

    cur_test = 9;
    exp_burst(32'h80, 2, 0, 1'b1, 4'h3);
    drive(32'h80, 20'd10, 3);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/simple_axi_write_burster.md
SIMPLE_AXI_WRITE_BURSTER -- requirements
Module: simple_axi_write_burster

Interface
REQ-001 SHALL have parameter AXI_ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter AXI_DATA_W, default 32, data width; legal values 16..1024, powers of 2.
REQ-003 SHALL have parameter LEN_W, default 20, width of the byte-length input.
REQ-004 SHALL have parameter MAX_BURST, default 16, maximum beats per burst; legal values power of 2, 1..256.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 4, maximum unacknowledged bursts; legal values 1..15.
REQ-006 SHALL have port clk, input, 1 bit, single clock; all logic rising-edge.
REQ-007 SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-008 SHALL have port m_wvalid, input, 1 bit, command/data valid.
REQ-009 SHALL have port m_wready, output, 1 bit, data beat accepted.
REQ-010 SHALL have port m_waddr, input, AXI_ADDR_W bits, start byte address, aligned to AXI_DATA_W/8.
REQ-011 SHALL have port m_wdata, input, AXI_DATA_W bits, beat data.
REQ-012 SHALL have port m_wlen, input, LEN_W bits, transfer length in bytes.
REQ-013 SHALL have port m_wlast, output, 1 bit, high on the final accepted beat of the transfer.
REQ-014 SHALL have port done, output, 1 bit, one-cycle pulse at transfer completion.
REQ-015 SHALL have port error, output, 1 bit, sticky; set by a non-OKAY bresp; cleared at the next command latch.
REQ-016 SHALL have the m_axi_aw* signals, AXI4 write-address channel (awid..awqos, awvalid out; awready in), widths per axi.vh.
REQ-017 SHALL have the m_axi_w* signals, AXI4 write-data channel (wdata, wstrb, wlast, wvalid out; wready in).
REQ-018 SHALL have the m_axi_b* signals, AXI4 write-response channel (bresp, bvalid in; bready out).

Function
REQ-019 SHALL implement FSM states IDLE -> CALC -> ADDR -> DATA, then DATA -> CALC while beats remain, DATA -> DRAIN on the last burst, and DRAIN -> IDLE.
REQ-020 SHALL, in IDLE with m_wvalid=1, latch the address and length and compute total_beats = ceil(m_wlen/(AXI_DATA_W/8)).
REQ-021 SHALL, in CALC, set burst beats = min(MAX_BURST, remaining beats, beats to the next 4 KB boundary) and register awlen = beats-1.
REQ-022 SHALL hold awvalid in ADDR until awready, with awvalid, awaddr and awlen stable; it SHALL stall in CALC while outstanding == MAX_OUTSTANDING.
REQ-023 SHALL, in DATA, set m_axi_wvalid = m_wvalid, m_wready = m_axi_wready, and m_axi_wdata = m_wdata combinationally.
REQ-024 SHALL assert m_axi_wlast on beat awlen of each burst.
REQ-025 SHALL drive wstrb all-ones, except on the final beat of the transfer: lower (m_wlen mod bytes) bytes set, or all-ones if the remainder is 0.
REQ-026 SHALL drive fixed fields: awid 0, awsize log2(AXI_DATA_W/8), awburst INCR, awlock 0, awcache 2, awprot 3'b010, awqos 0.
REQ-027 SHALL complete m_wlen=0 without AXI traffic: IDLE -> CALC -> IDLE, done pulsed, m_wlast not asserted.
REQ-028 SHALL keep the outstanding counter at +1 on an aw handshake and -1 on a b handshake; simultaneous events SHALL leave it unchanged.
REQ-029 SHALL assert m_wready only in DATA state, so data is never lost across burst boundaries.

Reset
REQ-030 SHALL, when rst=1 at a clock edge, force IDLE, outstanding=0, awvalid=0, wvalid=0, m_wready=0, m_wlast=0, done=0, error=0, and registered awaddr/awlen=0.
REQ-031 SHALL abandon an in-flight transfer on reset mid-transfer, with no handshake completion implied.

Configuration
REQ-032 SHALL, with SIMPLE_AXI_WRITE_BRESP_EN defined: bready=1, outstanding tracking active, DRAIN wait until outstanding==0, done pulsed then, error updated from bresp.
REQ-033 SHALL, without SIMPLE_AXI_WRITE_BRESP_EN: bready=1, no outstanding limit, DRAIN lasting one cycle, done pulsed after the last W handshake, error tied 0.

Structure
REQ-034 SHALL place in a shared package: the FSM state encoding, the AXI_BURST_INCR / AXI_RESP_OKAY constants, the axi_size-from-width function, and the 4 KB boundary constant.
REQ-035 SHALL use one sub-module, write_burst_calc, for combinational burst-length/4 KB/final-strobe arithmetic.

Verification
REQ-036 SHALL cover: addr 0x0, len 64, W=32, MAX_BURST=16 -> one burst, awlen=15, 16 beats, m_wlast on beat 16, wstrb 0xF throughout.
REQ-037 SHALL cover: addr 0xFF8, len 32 -> two bursts, awaddr 0xFF8 with awlen=1, then 0x1000 with awlen=5.
REQ-038 SHALL cover: len 10, W=32 -> 3 beats, final wstrb 0x3, m_wlast with the third beat.
REQ-039 SHALL cover: len 0 -> no awvalid, done pulse within 3 cycles.
REQ-040 SHALL cover: BRESP_EN, MAX_OUTSTANDING=1, bvalid delayed 20 cycles, bresp=SLVERR -> second awvalid held off until the b handshake, error=1, done after the final response.
REQ-041 SHALL cover: rst asserted mid-DATA with wready randomised -> all outputs at reset values next cycle, new transfer completes correctly.
